mem_image_loader: RTL and testbench

- Synthesizable boot loader upstream of Simple_Single_CPU; replaces hierarchical back-door preloading of instruction/data memories.
- Consumes one 32-bit word stream: instruction image (PC, N, N words) immediately followed by data image (SP, M, M words).
- Writes memories byte-serially, zero-fills unused data memory, presents initial PC and $sp, then asserts done_o to release the CPU.

---
 rtl/mem_image_loader_if.sv | 38 +++
 rtl/mem_image_loader.sv | 174 +++++++++++++++++
 tb/tb_mem_image_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_image_loader_if.sv
// Stream, memory-write and status signals of the boot image loader.
// The loader takes the slave view. The environment (source, memories, CPU) takes the master view.
interface mem_image_loader_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid_i;
    logic [31:0]       s_data_i;
    logic              s_ready_o;
    logic              im_we_o;
    logic [ADDR_W-1:0] im_addr_o;
    logic [7:0]        im_data_o;
    logic              dm_we_o;
    logic [ADDR_W-1:0] dm_addr_o;
    logic [7:0]        dm_data_o;
    logic [31:0]       pc_init_o;
    logic              pc_load_o;
    logic [31:0]       sp_init_o;
    logic              sp_load_o;
    logic              done_o;
    logic              err_o;
    logic [3:0]        dbg_state_o;

    modport slave (
        input  s_valid_i, s_data_i,
        output s_ready_o, im_we_o, im_addr_o, im_data_o,
               dm_we_o, dm_addr_o, dm_data_o,
               pc_init_o, pc_load_o, sp_init_o, sp_load_o,
               done_o, err_o, dbg_state_o
    );

    modport master (
        output s_valid_i, s_data_i,
        input  s_ready_o, im_we_o, im_addr_o, im_data_o,
               dm_we_o, dm_addr_o, dm_data_o,
               pc_init_o, pc_load_o, sp_init_o, sp_load_o,
               done_o, err_o, dbg_state_o
    );
endinterface

// File: rtl/mem_image_loader.sv
// Boot loader: streams an instruction image then a data image into byte-wide memories,
// zero-fills the rest of data memory, then releases the CPU with done_o.
// Stream handshake: a word transfers on a rising edge where s_valid_i and s_ready_o are both 1.
module mem_image_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_image_loader_if.slave   io_bus
);
    localparam int          CNT_W     = $clog2(MAX_WORDS + 1);
    localparam logic [34:0] MEM_BYTES = 35'(1) << ADDR_W;

    typedef enum logic [3:0] {
        S_I_PC, S_I_CNT, S_I_WORD, S_I_BYTE,
        S_D_SP, S_D_CNT, S_D_WORD, S_D_BYTE,
        S_D_FILL, S_DONE, S_ERR
    } state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_pc, r_sp, r_word;
    logic [ADDR_W-1:0] r_base, r_fill;
    logic [CNT_W-1:0]  r_cnt, r_k;
    logic [1:0]        r_b;
    logic              r_pc_load, r_sp_load;

    logic              w_ready, w_xfer;
    logic [34:0]       w_cnt_wide, w_cnt_bytes, w_pc_end;
    logic              w_cnt_big, w_i_bad, w_d_bad;
    logic [CNT_W-1:0]  w_k_next;
    logic              w_last_byte, w_more, w_skip_fill;
    logic [ADDR_W-1:0] w_off, w_fill_start;
    logic [7:0]        w_be_byte, w_le_byte;

    // Ready is forced low while reset is held so no output is active during reset.
    assign w_ready = rst_i & (r_state inside {S_I_PC, S_I_CNT, S_I_WORD,
                                              S_D_SP, S_D_CNT, S_D_WORD});
    assign w_xfer  = io_bus.s_valid_i & w_ready;

    // Range checks are done wide enough that PC + 4N can never wrap.
    assign w_cnt_wide  = {3'b000, io_bus.s_data_i};
    assign w_cnt_bytes = w_cnt_wide << 2;
    assign w_pc_end    = {3'b000, r_pc} + w_cnt_bytes;
    assign w_cnt_big   = w_cnt_wide > 35'(MAX_WORDS);
    assign w_i_bad     = w_cnt_big | (w_pc_end > MEM_BYTES);
    assign w_d_bad     = w_cnt_big | (w_cnt_bytes > MEM_BYTES);

    assign w_k_next     = r_k + CNT_W'(1);
    assign w_last_byte  = (r_b == 2'd3);
    assign w_more       = (w_k_next < r_cnt);
    assign w_off        = ADDR_W'({r_k, r_b});
    assign w_fill_start = ADDR_W'({r_cnt, 2'b00});
    assign w_skip_fill  = (35'({r_cnt, 2'b00}) == MEM_BYTES);
    assign w_be_byte    = 8'(r_word >> (5'd24 - {r_b, 3'b000}));
    assign w_le_byte    = 8'(r_word >> {r_b, 3'b000});

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= S_I_PC;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        io_bus.im_we_o   = 1'b0;
        io_bus.im_addr_o = '0;
        io_bus.im_data_o = '0;
        io_bus.dm_we_o   = 1'b0;
        io_bus.dm_addr_o = '0;
        io_bus.dm_data_o = '0;
        case (r_state)
            S_I_PC:   if (w_xfer) w_next = S_I_CNT;
            S_I_CNT: begin
                if (w_xfer) begin
                    if (w_i_bad)                    w_next = S_ERR;
                    else if (io_bus.s_data_i == '0) w_next = S_D_SP;
                    else                            w_next = S_I_WORD;
                end
            end
            S_I_WORD: if (w_xfer) w_next = S_I_BYTE;
            S_I_BYTE: begin
                io_bus.im_we_o   = 1'b1;
                io_bus.im_addr_o = r_base + w_off;
                io_bus.im_data_o = w_be_byte;
                if (w_last_byte) w_next = w_more ? S_I_WORD : S_D_SP;
            end
            S_D_SP:   if (w_xfer) w_next = S_D_CNT;
            S_D_CNT: begin
                if (w_xfer) begin
                    if (w_d_bad)                    w_next = S_ERR;
                    else if (io_bus.s_data_i == '0) w_next = S_D_FILL;
                    else                            w_next = S_D_WORD;
                end
            end
            S_D_WORD: if (w_xfer) w_next = S_D_BYTE;
            S_D_BYTE: begin
                io_bus.dm_we_o   = 1'b1;
                io_bus.dm_addr_o = w_off;
                io_bus.dm_data_o = w_le_byte;
                if (w_last_byte) begin
                    if (w_more)           w_next = S_D_WORD;
                    else if (w_skip_fill) w_next = S_DONE;
                    else                  w_next = S_D_FILL;
                end
            end
            S_D_FILL: begin
                io_bus.dm_we_o   = 1'b1;
                io_bus.dm_addr_o = r_fill;
                if (r_fill == '1) w_next = S_DONE;
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pc      <= '0;
            r_sp      <= '0;
            r_word    <= '0;
            r_base    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_k       <= '0;
            r_b       <= '0;
            r_pc_load <= 1'b0;
            r_sp_load <= 1'b0;
        end else begin
            r_pc_load <= 1'b0;
            r_sp_load <= 1'b0;
            case (r_state)
                S_I_PC: if (w_xfer) begin
                    r_pc      <= io_bus.s_data_i;
                    r_base    <= io_bus.s_data_i[ADDR_W-1:0];
                    r_pc_load <= 1'b1;
                end
                S_I_CNT: if (w_xfer) begin
                    r_cnt <= CNT_W'(io_bus.s_data_i);
                    r_k   <= '0;
                end
                S_I_WORD, S_D_WORD: if (w_xfer) begin
                    r_word <= io_bus.s_data_i;
                    r_b    <= '0;
                end
                S_I_BYTE, S_D_BYTE: begin
                    r_b <= r_b + 2'd1;
                    if (w_last_byte) begin
                        r_k <= w_k_next;
                        if (!w_more) r_fill <= w_fill_start;
                    end
                end
                S_D_SP: if (w_xfer) begin
                    r_sp      <= io_bus.s_data_i;
                    r_sp_load <= 1'b1;
                end
                S_D_CNT: if (w_xfer) begin
                    r_cnt  <= CNT_W'(io_bus.s_data_i);
                    r_k    <= '0;
                    r_fill <= '0;
                end
                S_D_FILL: r_fill <= r_fill + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign io_bus.s_ready_o   = w_ready;
    assign io_bus.pc_init_o   = r_pc;
    assign io_bus.pc_load_o   = r_pc_load;
    assign io_bus.sp_init_o   = r_sp;
    assign io_bus.sp_load_o   = r_sp_load;
    assign io_bus.done_o      = (r_state == S_DONE);
    assign io_bus.err_o       = (r_state == S_ERR);
    assign io_bus.dbg_state_o = r_state;
endmodule

// File: tb/tb_mem_image_loader.sv
// Self-checking bench for mem_image_loader: images are built from random and directed words,
// and the expected memory contents come from a byte-level model of the image format.
module tb_mem_image_loader;
  localparam int ADDR_W = 10;
  localparam int MEM    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mem_image_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard state
  logic [7:0]  obs_im[MEM], obs_dm[MEM], exp_im[MEM], exp_dm[MEM];
  logic [17:0] exp_q[$];
  int im_wr, dm_wr, pc_pulses, sp_pulses, both_we, ready_wr, dm_seq_bad;
  int cyc = 0, t_first, t_done, t_last_dm;
  bit xfer_seen, done_seen;
  logic [31:0] pc_seen, sp_seen;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.s_valid_i && bus.s_ready_o && !xfer_seen) begin
        xfer_seen = 1'b1;
        t_first   = cyc;
      end
      if (bus.im_we_o && bus.dm_we_o) both_we++;
      if ((bus.im_we_o || bus.dm_we_o) && bus.s_ready_o) ready_wr++;
      if (bus.im_we_o) begin
        im_wr++;
        obs_im[bus.im_addr_o] = bus.im_data_o;
      end
      if (bus.dm_we_o) begin
        dm_wr++;
        obs_dm[bus.dm_addr_o] = bus.dm_data_o;
        t_last_dm = cyc;
        if (exp_q.size() == 0) dm_seq_bad++;
        else if (exp_q.pop_front() !== {bus.dm_addr_o, bus.dm_data_o}) dm_seq_bad++;
      end
      if (bus.pc_load_o) begin
        pc_pulses++;
        pc_seen = bus.pc_init_o;
      end
      if (bus.sp_load_o) begin
        sp_pulses++;
        sp_seen = bus.sp_init_o;
      end
      if (bus.done_o && !done_seen) begin
        done_seen = 1'b1;
        t_done    = cyc;
      end
    end
  end

  task automatic clear_mon();
    for (int a = 0; a < MEM; a++) begin
      obs_im[a] = 8'hA5; obs_dm[a] = 8'hA5;
      exp_im[a] = 8'hA5; exp_dm[a] = 8'hA5;
    end
    exp_q.delete();
    im_wr = 0; dm_wr = 0; pc_pulses = 0; sp_pulses = 0;
    both_we = 0; ready_wr = 0; dm_seq_bad = 0;
    xfer_seen = 1'b0; done_seen = 1'b0;
  endtask

  function automatic logic [63:0] ctrl_vec();
    return 64'({bus.s_ready_o, bus.im_we_o, bus.im_addr_o, bus.im_data_o,
                bus.dm_we_o, bus.dm_addr_o, bus.dm_data_o,
                bus.pc_load_o, bus.sp_load_o, bus.done_o, bus.err_o});
  endfunction

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_ctrl"}, ctrl_vec(), 64'd0);
    check_val({tag, "_init"}, {bus.pc_init_o, bus.sp_init_o}, 64'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = $urandom;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int bubbles);
    int t;
    repeat (bubbles) begin
      @(negedge clk);
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = $urandom;
    end
    @(negedge clk);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = w;
    t = 0;
    while (!bus.s_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("stream_accept", 64'(bus.s_ready_o), 64'd1);
    @(posedge clk);
    #1 bus.s_valid_i = 1'b0;
  endtask

  function automatic int pick_bubbles(input int mode);
    return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
  endfunction

  // mode >= 0: fixed bubble count before every word; mode < 0: random 0..3
  task automatic run_image(input logic [31:0] pc, input int n, input logic [31:0] sp, input int m,
                           input logic [31:0] iw0, input logic [31:0] dw0, input int mode);
    logic [31:0] iw[256], dw[256];
    int t, bad_im, bad_dm, fill;
    clear_mon();
    for (int k = 0; k < 256; k++) begin
      iw[k] = (k == 0) ? iw0 : $urandom;
      dw[k] = (k == 0) ? dw0 : $urandom;
    end
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 4; b++)
        exp_im[(pc + 4 * k + b) % MEM] = 8'(iw[k] >> (24 - 8 * b));
    for (int k = 0; k < m; k++)
      for (int b = 0; b < 4; b++) begin
        exp_dm[4 * k + b] = 8'(dw[k] >> (8 * b));
        exp_q.push_back({10'(4 * k + b), 8'(dw[k] >> (8 * b))});
      end
    for (int a = 4 * m; a < MEM; a++) begin
      exp_dm[a] = 8'h00;
      exp_q.push_back({10'(a), 8'h00});
    end
    fill = MEM - 4 * m;

    send_word(pc, pick_bubbles(mode));
    send_word(32'(n), pick_bubbles(mode));
    for (int k = 0; k < n; k++) send_word(iw[k], pick_bubbles(mode));
    send_word(sp, pick_bubbles(mode));
    send_word(32'(m), pick_bubbles(mode));
    for (int k = 0; k < m; k++) send_word(dw[k], pick_bubbles(mode));

    t = 0;
    while (!bus.done_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_val("done", 64'(bus.done_o), 64'd1);
    bad_im = 0;
    bad_dm = 0;
    for (int a = 0; a < MEM; a++) begin
      if (obs_im[a] !== exp_im[a]) bad_im++;
      if (obs_dm[a] !== exp_dm[a]) bad_dm++;
    end
    check_val("im_bytes_bad", 64'(bad_im), 64'd0);
    check_val("dm_bytes_bad", 64'(bad_dm), 64'd0);
    check_val("dm_order_bad", 64'(dm_seq_bad), 64'd0);
    check_val("dm_left", 64'(exp_q.size()), 64'd0);
    check_val("im_writes", 64'(im_wr), 64'(4 * n));
    check_val("dm_writes", 64'(dm_wr), 64'(MEM));
    check_val("pc_pulses", 64'(pc_pulses), 64'd1);
    check_val("pc_value", 64'(pc_seen), 64'(pc));
    check_val("sp_pulses", 64'(sp_pulses), 64'd1);
    check_val("sp_value", 64'(sp_seen), 64'(sp));
    check_val("init_held", {bus.pc_init_o, bus.sp_init_o}, {pc, sp});
    check_val("err_low", 64'(bus.err_o), 64'd0);
    check_val("ready_done", 64'(bus.s_ready_o), 64'd0);
    check_val("both_we", 64'(both_we), 64'd0);
    check_val("write_while_ready", 64'(ready_wr), 64'd0);
    check_val("done_after_last", 64'(t_done - t_last_dm), 64'd1);
    if (mode == 0)
      check_val("load_cycles", 64'(t_done - t_first), 64'(4 + 5 * n + 5 * m + fill));
  endtask

  task automatic expect_err(input string tag);
    @(negedge clk);
    check_val({tag, "_err"}, 64'(bus.err_o), 64'd1);
    check_val({tag, "_ready"}, 64'(bus.s_ready_o), 64'd0);
    bus.s_valid_i = 1'b1;
    repeat (20) begin
      bus.s_data_i = $urandom;
      @(negedge clk);
    end
    bus.s_valid_i = 1'b0;
    check_val({tag, "_writes"}, 64'(im_wr + dm_wr), 64'd0);
    check_val({tag, "_done"}, 64'(bus.done_o), 64'd0);
    check_val({tag, "_stuck"}, 64'(bus.err_o), 64'd1);
  endtask

  initial begin
    int n, m;
    logic [31:0] pc;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    clear_mon();

    // directed image, back to back
    reset_dut();
    run_image(32'h10, 1, 32'h400, 1, 32'h2008_0005, 32'hDEAD_BEEF, 0);
    check_val("im_10_13", {obs_im[16], obs_im[17], obs_im[18], obs_im[19]}, 64'h2008_0005);
    check_val("dm_0_3", {obs_dm[0], obs_dm[1], obs_dm[2], obs_dm[3]}, 64'hEFBE_ADDE);
    check_val("dm_4_1023", {obs_dm[4], obs_dm[1023]}, 64'd0);

    // same image with 3-cycle bubbles
    reset_dut();
    run_image(32'h10, 1, 32'h400, 1, 32'h2008_0005, 32'hDEAD_BEEF, 3);
    check_val("bub_im_10_13", {obs_im[16], obs_im[17], obs_im[18], obs_im[19]}, 64'h2008_0005);
    check_val("bub_dm_0_3", {obs_dm[0], obs_dm[1], obs_dm[2], obs_dm[3]}, 64'hEFBE_ADDE);

    // empty images
    reset_dut();
    run_image(32'h0, 0, 32'h3FC, 0, 32'h0, 32'h0, 0);

    // instruction image overruns memory
    reset_dut();
    clear_mon();
    send_word(32'h3FC, 0);
    send_word(32'd2, 0);
    expect_err("pc_overrun");

    // data count too large
    reset_dut();
    clear_mon();
    send_word(32'h0, 0);
    send_word(32'd0, 0);
    send_word(32'h400, 0);
    send_word(32'd257, 0);
    expect_err("m_257");

    // instruction count too large
    reset_dut();
    clear_mon();
    send_word(32'h0, 0);
    send_word(32'd257, 0);
    expect_err("n_257");

    // data image fills memory exactly, no zero fill
    reset_dut();
    run_image(32'h20, 1, 32'h400, 256, $urandom, $urandom, 0);

    // instruction image ends exactly at top of memory
    reset_dut();
    run_image(32'h3F8, 2, 32'h200, 3, $urandom, $urandom, 0);

    // reset during second instruction byte, then full reload
    reset_dut();
    clear_mon();
    send_word(32'h100, 0);
    send_word(32'd2, 0);
    send_word(32'h1122_3344, 0);
    @(negedge clk);
    @(negedge clk);
    check_val("mid_byte_addr", {63'(bus.im_addr_o), bus.im_we_o}, {63'h101, 1'b1});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("mid_reset");
    rst_n = 1'b1;
    run_image(32'h100, 2, 32'h3F0, 2, $urandom, $urandom, 0);

    // random images with random bubbles
    for (int i = 0; i < 4; i++) begin
      n  = $urandom_range(0, 8);
      m  = $urandom_range(0, 8);
      pc = $urandom_range(0, MEM - 4 * n);
      reset_dut();
      run_image(pc, n, $urandom, m, $urandom, $urandom, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
